// File: rtl/mc_main_fsm.sv
// Main control FSM for the multicycle RV32I core.
// Steps the shared memory/ALU/PC/IR/register-file datapath through each
// instruction, one state per cycle. Memory states wait on mem_ready.
// The ALUOp output feeds the ALU decoder that sits beside this block.
module mc_main_fsm #(
    parameter int unsigned USE_MEM_READY = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       mem_ready,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic       PCUpdate,
    output logic       Branch,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       illegal_op,
    output logic [3:0] state_o
);

    // Supported opcodes (same set as the single-cycle opdecoder).
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    // Operand and result select encodings.
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;
    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   mem_rdy;
    logic   op_known;

    // Effective handshake: tied high when the memory never stalls.
    always_comb begin
        mem_rdy = 1'b1;
        if (USE_MEM_READY != 0) begin
            mem_rdy = mem_ready;
        end
    end

    // Flag opcodes this FSM knows how to sequence.
    always_comb begin
        op_known = 1'b0;
        case (op)
            OP_LW, OP_SW, OP_R, OP_IALU, OP_BEQ, OP_JAL: op_known = 1'b1;
            default:                                     op_known = 1'b0;
        endcase
    end

    // State register with synchronous reset back to FETCH.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; unreachable codes fall back to FETCH.
    always_comb begin
        state_d = S_FETCH;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    state_d = mem_rdy ? S_DECODE : S_FETCH;
                end
                S_DECODE: begin
                    case (op)
                        OP_LW, OP_SW: state_d = S_MEMADR;
                        OP_R:         state_d = S_EXECR;
                        OP_IALU:      state_d = S_EXECI;
                        OP_BEQ:       state_d = S_BEQ;
                        OP_JAL:       state_d = S_JAL;
                        default:      state_d = S_FETCH;
                    endcase
                end
                S_MEMADR: begin
                    case (op)
                        OP_LW:   state_d = S_MEMREAD;
                        OP_SW:   state_d = S_MEMWRITE;
                        default: state_d = S_FETCH;
                    endcase
                end
                S_MEMREAD: begin
                    state_d = mem_rdy ? S_MEMWB : S_MEMREAD;
                end
                S_MEMWB: begin
                    state_d = S_FETCH;
                end
                S_MEMWRITE: begin
                    state_d = mem_rdy ? S_FETCH : S_MEMWRITE;
                end
                S_EXECR, S_EXECI, S_JAL: begin
                    state_d = S_ALUWB;
                end
                S_ALUWB: begin
                    state_d = S_FETCH;
                end
                S_BEQ: begin
                    state_d = S_FETCH;
                end
                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end
    end

    // Moore output decode; reset shows FETCH selects with every enable low.
    always_comb begin
        AdrSrc     = 1'b0;
        IRWrite    = 1'b0;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_RS2;
        ALUOp      = ALUOP_ADD;
        ResultSrc  = RES_ALUOUT;
        PCUpdate   = 1'b0;
        Branch     = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        illegal_op = 1'b0;
        if (reset) begin
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURES;
        end else begin
            case (state_q)
                S_FETCH: begin
                    IRWrite   = mem_rdy;
                    ALUSrcB   = SRCB_FOUR;
                    ResultSrc = RES_ALURES;
                    PCUpdate  = mem_rdy;
                end
                S_DECODE: begin
                    ALUSrcA    = SRCA_OLDPC;
                    ALUSrcB    = SRCB_IMM;
                    illegal_op = ~op_known;
                end
                S_MEMADR: begin
                    ALUSrcA = SRCA_RS1;
                    ALUSrcB = SRCB_IMM;
                end
                S_MEMREAD: begin
                    AdrSrc = 1'b1;
                end
                S_MEMWB: begin
                    ResultSrc = RES_DATA;
                    RegWrite  = 1'b1;
                end
                S_MEMWRITE: begin
                    AdrSrc   = 1'b1;
                    MemWrite = 1'b1;
                end
                S_EXECR: begin
                    ALUSrcA = SRCA_RS1;
                    ALUOp   = ALUOP_FUNC;
                end
                S_EXECI: begin
                    ALUSrcA = SRCA_RS1;
                    ALUSrcB = SRCB_IMM;
                    ALUOp   = ALUOP_FUNC;
                end
                S_ALUWB: begin
                    RegWrite = 1'b1;
                end
                S_BEQ: begin
                    ALUSrcA = SRCA_RS1;
                    ALUOp   = ALUOP_SUB;
                    Branch  = 1'b1;
                end
                S_JAL: begin
                    ALUSrcA  = SRCA_OLDPC;
                    ALUSrcB  = SRCB_FOUR;
                    PCUpdate = 1'b1;
                end
                default: begin
                    AdrSrc = 1'b0;
                end
            endcase
        end
    end

    // Immediate format straight from the opcode, independent of state.
    always_comb begin
        ImmSrc = 2'b00;
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_mc_main_fsm.sv
// Testbench for mc_main_fsm: a table of per-cycle vectors with
// hand-computed expected state and control outputs, plus a few
// hand-written sequences for opcode changes and ImmSrc decoding.
module tb_mc_main_fsm;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_ILL  = 7'b1111111;

    // Control word order:
    // {AdrSrc, IRWrite, ALUSrcA, ALUSrcB, ALUOp, ResultSrc, PCUpdate, Branch, RegWrite, MemWrite, illegal_op}
    localparam logic [14:0] C_FETCH  = 15'b0_1_00_10_00_10_1_0_0_0_0;
    localparam logic [14:0] C_FWAIT  = 15'b0_0_00_10_00_10_0_0_0_0_0;
    localparam logic [14:0] C_DEC    = 15'b0_0_01_01_00_00_0_0_0_0_0;
    localparam logic [14:0] C_DECILL = 15'b0_0_01_01_00_00_0_0_0_0_1;
    localparam logic [14:0] C_MADR   = 15'b0_0_10_01_00_00_0_0_0_0_0;
    localparam logic [14:0] C_MRD    = 15'b1_0_00_00_00_00_0_0_0_0_0;
    localparam logic [14:0] C_MWB    = 15'b0_0_00_00_00_01_0_0_1_0_0;
    localparam logic [14:0] C_MWR    = 15'b1_0_00_00_00_00_0_0_0_1_0;
    localparam logic [14:0] C_EXR    = 15'b0_0_10_00_10_00_0_0_0_0_0;
    localparam logic [14:0] C_EXI    = 15'b0_0_10_01_10_00_0_0_0_0_0;
    localparam logic [14:0] C_AWB    = 15'b0_0_00_00_00_00_0_0_1_0_0;
    localparam logic [14:0] C_BEQ    = 15'b0_0_10_00_01_00_0_1_0_0_0;
    localparam logic [14:0] C_JAL    = 15'b0_0_01_10_00_00_1_0_0_0_0;

    typedef struct {
        logic        rst;
        logic [6:0]  op;
        logic        rdy;
        logic [3:0]  expState;
        logic [14:0] expCtl;
        logic [1:0]  expImm;
    } vec_t;

    logic        clk;
    logic        reset;
    logic [6:0]  op;
    logic        mem_ready;
    logic        AdrSrc;
    logic        IRWrite;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ALUOp;
    logic [1:0]  ResultSrc;
    logic [1:0]  ImmSrc;
    logic        PCUpdate;
    logic        Branch;
    logic        RegWrite;
    logic        MemWrite;
    logic        illegal_op;
    logic [3:0]  state_o;

    int   nCompared;
    int   nMismatched;
    vec_t vecs[$];

    mc_main_fsm #(.USE_MEM_READY(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .mem_ready (mem_ready),
        .AdrSrc    (AdrSrc),
        .IRWrite   (IRWrite),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ALUOp     (ALUOp),
        .ResultSrc (ResultSrc),
        .ImmSrc    (ImmSrc),
        .PCUpdate  (PCUpdate),
        .Branch    (Branch),
        .RegWrite  (RegWrite),
        .MemWrite  (MemWrite),
        .illegal_op(illegal_op),
        .state_o   (state_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(input logic r, input logic [6:0] o, input logic d,
                                input logic [3:0] s, input logic [14:0] c, input logic [1:0] i);
        vec_t v;
        v.rst      = r;
        v.op       = o;
        v.rdy      = d;
        v.expState = s;
        v.expCtl   = c;
        v.expImm   = i;
        return v;
    endfunction

    task automatic applyStimulus(input logic r, input logic [6:0] o, input logic d);
        reset     = r;
        op        = o;
        mem_ready = d;
    endtask

    task automatic compareField(input string name, input logic [31:0] got, input logic [31:0] want);
        nCompared++;
        if (got !== want) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, got, want);
        end
    endtask

    task automatic checkOutput(input string name, input logic [3:0] st,
                               input logic [14:0] ctl, input logic [1:0] imm);
        logic [14:0] actCtl;
        actCtl = {AdrSrc, IRWrite, ALUSrcA, ALUSrcB, ALUOp, ResultSrc,
                  PCUpdate, Branch, RegWrite, MemWrite, illegal_op};
        compareField({name, " state"}, 32'(state_o), 32'(st));
        compareField({name, " ctl"}, 32'(actCtl), 32'(ctl));
        compareField({name, " imm"}, 32'(ImmSrc), 32'(imm));
    endtask

    // One cycle: drive after the edge, check at the falling edge, then clock.
    task automatic runCycle(input string name, input logic r, input logic [6:0] o, input logic d,
                            input logic [3:0] st, input logic [14:0] ctl, input logic [1:0] imm);
        applyStimulus(r, o, d);
        @(negedge clk);
        checkOutput(name, st, ctl, imm);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [6:0] immOps [4];
        logic [1:0] immExp [4];

        nCompared   = 0;
        nMismatched = 0;
        applyStimulus(1'b1, OP_LW, 1'b1);

        // Reset, then lw
        vecs.push_back(mk(1, OP_LW, 1, 4'd0, C_FWAIT, 2'b00));
        vecs.push_back(mk(1, OP_LW, 1, 4'd0, C_FWAIT, 2'b00));
        vecs.push_back(mk(0, OP_LW, 1, 4'd0, C_FETCH, 2'b00));
        vecs.push_back(mk(0, OP_LW, 1, 4'd1, C_DEC,   2'b00));
        vecs.push_back(mk(0, OP_LW, 1, 4'd2, C_MADR,  2'b00));
        vecs.push_back(mk(0, OP_LW, 1, 4'd3, C_MRD,   2'b00));
        vecs.push_back(mk(0, OP_LW, 1, 4'd4, C_MWB,   2'b00));
        // sw with two stall cycles in MEMWRITE
        vecs.push_back(mk(0, OP_SW, 1, 4'd0, C_FETCH, 2'b01));
        vecs.push_back(mk(0, OP_SW, 1, 4'd1, C_DEC,   2'b01));
        vecs.push_back(mk(0, OP_SW, 1, 4'd2, C_MADR,  2'b01));
        vecs.push_back(mk(0, OP_SW, 0, 4'd5, C_MWR,   2'b01));
        vecs.push_back(mk(0, OP_SW, 0, 4'd5, C_MWR,   2'b01));
        vecs.push_back(mk(0, OP_SW, 1, 4'd5, C_MWR,   2'b01));
        // R, I-ALU, jal, beq back-to-back
        vecs.push_back(mk(0, OP_R,    1, 4'd0,  C_FETCH, 2'b00));
        vecs.push_back(mk(0, OP_R,    1, 4'd1,  C_DEC,   2'b00));
        vecs.push_back(mk(0, OP_R,    1, 4'd6,  C_EXR,   2'b00));
        vecs.push_back(mk(0, OP_R,    1, 4'd8,  C_AWB,   2'b00));
        vecs.push_back(mk(0, OP_IALU, 1, 4'd0,  C_FETCH, 2'b00));
        vecs.push_back(mk(0, OP_IALU, 1, 4'd1,  C_DEC,   2'b00));
        vecs.push_back(mk(0, OP_IALU, 1, 4'd7,  C_EXI,   2'b00));
        vecs.push_back(mk(0, OP_IALU, 1, 4'd8,  C_AWB,   2'b00));
        vecs.push_back(mk(0, OP_JAL,  1, 4'd0,  C_FETCH, 2'b11));
        vecs.push_back(mk(0, OP_JAL,  1, 4'd1,  C_DEC,   2'b11));
        vecs.push_back(mk(0, OP_JAL,  1, 4'd10, C_JAL,   2'b11));
        vecs.push_back(mk(0, OP_JAL,  1, 4'd8,  C_AWB,   2'b11));
        vecs.push_back(mk(0, OP_BEQ,  1, 4'd0,  C_FETCH, 2'b10));
        vecs.push_back(mk(0, OP_BEQ,  1, 4'd1,  C_DEC,   2'b10));
        vecs.push_back(mk(0, OP_BEQ,  1, 4'd9,  C_BEQ,   2'b10));
        // Fetch stall for three cycles, then lw with a MEMREAD stall
        vecs.push_back(mk(0, OP_LW, 0, 4'd0, C_FWAIT, 2'b00));
        vecs.push_back(mk(0, OP_LW, 0, 4'd0, C_FWAIT, 2'b00));
        vecs.push_back(mk(0, OP_LW, 0, 4'd0, C_FWAIT, 2'b00));
        vecs.push_back(mk(0, OP_LW, 1, 4'd0, C_FETCH, 2'b00));
        vecs.push_back(mk(0, OP_LW, 1, 4'd1, C_DEC,   2'b00));
        vecs.push_back(mk(0, OP_LW, 1, 4'd2, C_MADR,  2'b00));
        vecs.push_back(mk(0, OP_LW, 0, 4'd3, C_MRD,   2'b00));
        vecs.push_back(mk(0, OP_LW, 1, 4'd3, C_MRD,   2'b00));
        vecs.push_back(mk(0, OP_LW, 1, 4'd4, C_MWB,   2'b00));
        // Illegal opcode
        vecs.push_back(mk(0, OP_ILL, 1, 4'd0, C_FETCH,  2'b00));
        vecs.push_back(mk(0, OP_ILL, 1, 4'd1, C_DECILL, 2'b00));
        vecs.push_back(mk(0, OP_ILL, 1, 4'd0, C_FETCH,  2'b00));
        // sw interrupted by reset in MEMWRITE
        vecs.push_back(mk(0, OP_SW, 1, 4'd1, C_DEC,   2'b01));
        vecs.push_back(mk(0, OP_SW, 1, 4'd2, C_MADR,  2'b01));
        vecs.push_back(mk(1, OP_SW, 1, 4'd5, C_FWAIT, 2'b01));
        vecs.push_back(mk(0, OP_SW, 1, 4'd0, C_FETCH, 2'b01));

        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            runCycle($sformatf("row%0d", i), vecs[i].rst, vecs[i].op, vecs[i].rdy,
                     vecs[i].expState, vecs[i].expCtl, vecs[i].expImm);
        end

        // Opcode changes from lw to R while in MEMADR: abandon to FETCH
        runCycle("opchg_decode", 1'b0, OP_LW, 1'b1, 4'd1, C_DEC,   2'b00);
        runCycle("opchg_memadr", 1'b0, OP_R,  1'b1, 4'd2, C_MADR,  2'b00);
        runCycle("opchg_fetch",  1'b0, OP_R,  1'b1, 4'd0, C_FETCH, 2'b00);

        // ImmSrc follows op without a clock edge
        immOps[0] = OP_LW;  immExp[0] = 2'b00;
        immOps[1] = OP_SW;  immExp[1] = 2'b01;
        immOps[2] = OP_BEQ; immExp[2] = 2'b10;
        immOps[3] = OP_JAL; immExp[3] = 2'b11;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, immOps[k], 1'b1);
            #1;
            compareField($sformatf("immsrc%0d", k), 32'(ImmSrc), 32'(immExp[k]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
